// File: rtl/alarm_level_encoder_pkg.sv
// Shared types and constants for the alarm level encoder: FSM states, level
// codes, packed-word field positions and the per-axis tilt quantizer.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUANT  = 2'd1,
    ST_FILTER = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [3:0] LVL_FLAT = 4'd0;
  localparam logic [3:0] LVL_LOW  = 4'd1;
  localparam logic [3:0] LVL_MID  = 4'd2;
  localparam logic [3:0] LVL_HIGH = 4'd3;
  localparam logic [3:0] LVL_SAT  = 4'd4;

  localparam logic [2:0] LIGHT_SILENT = 3'd6;

  localparam int X_LVL_MSB = 11;
  localparam int X_LVL_LSB = 8;
  localparam int Y_LVL_MSB = 3;
  localparam int Y_LVL_LSB = 0;

  // |v| is carried in 13 bits so that -2048 becomes +2048 rather than wrapping.
  function automatic logic [3:0] axis_level(input logic [11:0] v,
                                            input logic [12:0] t0,
                                            input logic [12:0] t1,
                                            input logic [12:0] t2,
                                            input logic [12:0] t3);
    logic [12:0] ext;
    logic [12:0] mag;
    ext = {v[11], v};
    mag = v[11] ? (~ext + 13'd1) : ext;
    if      (mag < t0) return LVL_FLAT;
    else if (mag < t1) return LVL_LOW;
    else if (mag < t2) return LVL_MID;
    else if (mag < t3) return LVL_HIGH;
    else               return LVL_SAT;
  endfunction

endpackage

// File: rtl/alarm_level_encoder_if.sv
// Sample handshake from the sensor readout side plus the level code / mode
// select bundle consumed by the beeper.
interface alarm_level_encoder_if;

  logic        sample_valid;
  logic        sample_ready;
  logic        sample_sel;
  logic [11:0] x_raw;
  logic [11:0] y_raw;
  logic [15:0] light_raw;
  logic [15:0] data;
  logic        select;
  logic        data_valid;

  modport master (
    output sample_valid, sample_sel, x_raw, y_raw, light_raw,
    input  sample_ready, data, select, data_valid
  );

  modport slave (
    input  sample_valid, sample_sel, x_raw, y_raw, light_raw,
    output sample_ready, data, select, data_valid
  );

endinterface

// File: rtl/alarm_level_encoder_rate_tick_gen.sv
// 50% square wave at TOGGLE_HZ toggle rate: the output flips every
// CLK_HZ/(2*TOGGLE_HZ) cycles (at least every cycle).
module rate_tick_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TOGGLE_HZ = 1
) (
  input  logic clk,
  input  logic rst,
  output logic wave
);

  localparam int DIV_RAW = CLK_HZ / (2 * TOGGLE_HZ);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // The counter reloads to zero on the same edge that flips the output, so the
  // first flip lands exactly DIV cycles after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_level_encoder.sv
// Quantizes accelerometer / light samples into beeper level codes and makes the
// four beep-rate waves. Define ALARM_PERSIST_EN to enable the persistence filter.
module alarm_level_encoder
  import alarm_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FAST_HZ     = 8,
  parameter int MOD_HZ      = 4,
  parameter int SLOW_HZ     = 2,
  parameter int SLOWER_HZ   = 1,
  parameter int TILT_T0     = 64,
  parameter int TILT_T1     = 128,
  parameter int TILT_T2     = 256,
  parameter int TILT_T3     = 512,
  parameter int LIGHT_SHIFT = 10,
  parameter int PERSIST_N   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alarm_level_encoder_if.slave bus,
  output logic                 slower_clk,
  output logic                 slow_clk,
  output logic                 moderate_clk,
  output logic                 fast_clk
);

  if (PERSIST_N < 1 || PERSIST_N > 15) begin : g_bad_persist
    $error("PERSIST_N must lie in 1..15");
  end

  rate_tick_gen #(.CLK_HZ(CLK_HZ), .TOGGLE_HZ(SLOWER_HZ)) u_slower (
    .clk(clk), .rst(rst), .wave(slower_clk));
  rate_tick_gen #(.CLK_HZ(CLK_HZ), .TOGGLE_HZ(SLOW_HZ)) u_slow (
    .clk(clk), .rst(rst), .wave(slow_clk));
  rate_tick_gen #(.CLK_HZ(CLK_HZ), .TOGGLE_HZ(MOD_HZ)) u_moderate (
    .clk(clk), .rst(rst), .wave(moderate_clk));
  rate_tick_gen #(.CLK_HZ(CLK_HZ), .TOGGLE_HZ(FAST_HZ)) u_fast (
    .clk(clk), .rst(rst), .wave(fast_clk));

  state_t      state;
  logic        ready_q;
  logic [15:0] data_q;
  logic        select_q;
  logic        data_valid_q;
  logic        sel_r;
  logic [11:0] x_r;
  logic [11:0] y_r;
  logic [15:0] light_r;
  logic [15:0] q_word;
  logic        commit_pend;

  logic [15:0] quant_word;
  logic [15:0] light_shifted;
  logic [2:0]  light_lvl;
  logic        mode_switch;
  logic        commit_now;

  assign bus.sample_ready = ready_q;
  assign bus.data         = data_q;
  assign bus.select       = select_q;
  assign bus.data_valid   = data_valid_q;

  assign light_shifted = light_r >> LIGHT_SHIFT;
  assign light_lvl     = (light_shifted > 16'(LIGHT_SILENT)) ? LIGHT_SILENT
                                                             : light_shifted[2:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    quant_word = '0;
    if (sel_r) begin
      quant_word[2:0] = light_lvl;
    end else begin
      quant_word[X_LVL_MSB:X_LVL_LSB] = axis_level(x_r, 13'(TILT_T0), 13'(TILT_T1),
                                                   13'(TILT_T2), 13'(TILT_T3));
      quant_word[Y_LVL_MSB:Y_LVL_LSB] = axis_level(y_r, 13'(TILT_T0), 13'(TILT_T1),
                                                   13'(TILT_T2), 13'(TILT_T3));
    end
  end

  assign mode_switch = (sel_r != select_q);

`ifdef ALARM_PERSIST_EN
  localparam logic [3:0] PERSIST_LIM = 4'(PERSIST_N);

  logic [15:0] cand;
  logic [3:0]  persist_cnt;
  logic [15:0] cand_next;
  logic [3:0]  cnt_next;

  // A mode change re-seeds the candidate so the new mode starts its own run.
  always_comb begin
    cand_next = cand;
    cnt_next  = persist_cnt;
    if (mode_switch || (q_word != cand)) begin
      cand_next = q_word;
      cnt_next  = 4'd1;
    end else if (persist_cnt != 4'd15) begin
      cnt_next = persist_cnt + 4'd1;
    end
    commit_now = mode_switch || ((cnt_next >= PERSIST_LIM) && (cand_next != data_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand        <= '0;
      persist_cnt <= '0;
    end else if (state == ST_FILTER) begin
      cand        <= cand_next;
      persist_cnt <= cnt_next;
    end
  end
`else
  assign commit_now = mode_switch || (q_word != data_q);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ready_q      <= 1'b1;
      data_q       <= 16'(LIGHT_SILENT);
      select_q     <= 1'b1;
      data_valid_q <= 1'b0;
      sel_r        <= 1'b0;
      x_r          <= '0;
      y_r          <= '0;
      light_r      <= '0;
      q_word       <= '0;
      commit_pend  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.sample_valid) begin
            sel_r   <= bus.sample_sel;
            x_r     <= bus.x_raw;
            y_r     <= bus.y_raw;
            light_r <= bus.light_raw;
            ready_q <= 1'b0;
            state   <= ST_QUANT;
          end
        end
        ST_QUANT: begin
          q_word <= quant_word;
          state  <= ST_FILTER;
        end
        ST_FILTER: begin
          commit_pend <= commit_now;
          state       <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (commit_pend) begin
            data_q       <= q_word;
            select_q     <= sel_r;
            data_valid_q <= 1'b1;
          end
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
